// File: rtl/mu_sweep_ctrl.sv
// Mu sweep controller: debounced buttons and per-frame auto sweep pick the next mu,
// then the downstream iterator is restarted, run to completion or timeout, and held for display.
module mu_sweep_ctrl #(
    parameter logic [17:0] MU_MIN     = 18'h2_0000,
    parameter logic [17:0] MU_MAX     = 18'h3_FFFF,
    parameter logic [17:0] MU_STEP    = 18'h0_0040,
    parameter int          DEB_CYCLES = 250000,
    parameter int          TIMEOUT    = 1024
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        frame_start,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        auto_en,
    input  logic        iter_done,
    output logic [17:0] mu,
    output logic        iter_rst_n,
    output logic        mu_valid,
    output logic        busy
);

    localparam int                DEB_W    = $clog2(DEB_CYCLES + 1);
    localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam int                RUN_W    = $clog2(TIMEOUT + 1);
    localparam logic [RUN_W-1:0]  RUN_LAST = RUN_W'(TIMEOUT - 1);
    localparam logic [18:0]       BIG_STEP = {1'b0, MU_STEP} << 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESTART = 2'd1,
        RUN     = 2'd2,
        HOLD    = 2'd3
    } state_t;

    // Next mu from the pending flags and auto sweep; sums are 19 bits so overflow is visible.
    function automatic logic [17:0] next_mu(input logic [17:0] cur, input logic up,
                                            input logic dn, input logic au);
        logic [18:0] wide;
        logic [17:0] res;
        wide = {1'b0, cur};
        res  = cur;
        case ({up, dn})
            2'b10: begin
                wide = {1'b0, cur} + BIG_STEP;
                res  = (wide > {1'b0, MU_MAX}) ? MU_MAX : wide[17:0];
            end
            2'b01: res = ({1'b0, cur} < ({1'b0, MU_MIN} + BIG_STEP)) ? MU_MIN : cur - BIG_STEP[17:0];
            2'b11: res = cur;
            default: begin
                if (au) begin
                    wide = {1'b0, cur} + {1'b0, MU_STEP};
                    res  = (wide > {1'b0, MU_MAX}) ? MU_MIN : wide[17:0];
                end else begin
                    res = cur;
                end
            end
        endcase
        return res;
    endfunction

    logic [1:0]       btn_raw_s;
    logic [1:0]       sync1_r, sync2_r, deb_r, press_r;
    logic [DEB_W-1:0] deb_cnt_r [2];
    logic             pend_up_r, pend_down_r, consume_s;
    state_t           state_r, state_nxt_s;
    logic [17:0]      mu_r, mu_nxt_s, mu_cand_s;
    logic             rst_cnt_r, rst_cnt_nxt_s;
    logic [RUN_W-1:0] run_cnt_r, run_cnt_nxt_s;
    logic             iter_rst_n_r, iter_rst_n_nxt_s;
    logic             mu_valid_r, mu_valid_nxt_s;
    logic             busy_r, busy_nxt_s;

    assign btn_raw_s = {btn_down, btn_up};
    assign consume_s = (state_r == HOLD) && frame_start;

    // Button synchronizers, debouncers and one-cycle press pulses (bit 0 = up, bit 1 = down).
    always_ff @(posedge CLK) begin
        if (!RST) begin
            sync1_r <= 2'b00;
            sync2_r <= 2'b00;
            deb_r   <= 2'b00;
            press_r <= 2'b00;
            for (int i = 0; i < 2; i++) deb_cnt_r[i] <= {DEB_W{1'b0}};
        end else begin
            sync1_r <= btn_raw_s;
            sync2_r <= sync1_r;
            for (int i = 0; i < 2; i++) begin
                press_r[i] <= 1'b0;
                if (sync2_r[i] == deb_r[i]) begin
                    deb_cnt_r[i] <= {DEB_W{1'b0}};
                end else if (deb_cnt_r[i] == DEB_LAST) begin
                    deb_r[i]     <= sync2_r[i];
                    deb_cnt_r[i] <= {DEB_W{1'b0}};
                    press_r[i]   <= sync2_r[i];
                end else begin
                    deb_cnt_r[i] <= deb_cnt_r[i] + DEB_W'(1);
                end
            end
        end
    end

    // Pending flags: a press arriving on the consume cycle is kept for the following frame.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            pend_up_r   <= 1'b0;
            pend_down_r <= 1'b0;
        end else begin
            pend_up_r   <= press_r[0] | (pend_up_r & ~consume_s);
            pend_down_r <= press_r[1] | (pend_down_r & ~consume_s);
        end
    end

    // Next-state, mu and counter logic; outputs are decoded from the next state so they register with it.
    always_comb begin
        state_nxt_s      = state_r;
        mu_nxt_s         = mu_r;
        rst_cnt_nxt_s    = 1'b0;
        run_cnt_nxt_s    = {RUN_W{1'b0}};
        mu_cand_s        = next_mu(mu_r, pend_up_r, pend_down_r, auto_en);
        iter_rst_n_nxt_s = 1'b1;
        mu_valid_nxt_s   = 1'b0;
        busy_nxt_s       = 1'b0;
        case (state_r)
            // Stay one visible cycle with iter_rst_n high after reset before restarting.
            IDLE:    state_nxt_s = iter_rst_n_r ? RESTART : IDLE;
            RESTART: begin
                if (rst_cnt_r) state_nxt_s = RUN;
                else           rst_cnt_nxt_s = 1'b1;
            end
            RUN: begin
                if (iter_done || (run_cnt_r == RUN_LAST)) state_nxt_s = HOLD;
                else                                      run_cnt_nxt_s = run_cnt_r + RUN_W'(1);
            end
            HOLD: begin
                if (frame_start && (mu_cand_s != mu_r)) begin
                    state_nxt_s = RESTART;
                    mu_nxt_s    = mu_cand_s;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
        case (state_nxt_s)
            IDLE:    begin iter_rst_n_nxt_s = 1'b1; mu_valid_nxt_s = 1'b0; busy_nxt_s = 1'b0; end
            RESTART: begin iter_rst_n_nxt_s = 1'b0; mu_valid_nxt_s = 1'b0; busy_nxt_s = 1'b1; end
            RUN:     begin iter_rst_n_nxt_s = 1'b1; mu_valid_nxt_s = 1'b0; busy_nxt_s = 1'b1; end
            HOLD:    begin iter_rst_n_nxt_s = 1'b1; mu_valid_nxt_s = 1'b1; busy_nxt_s = 1'b0; end
            default: begin iter_rst_n_nxt_s = 1'b0; mu_valid_nxt_s = 1'b0; busy_nxt_s = 1'b0; end
        endcase
    end

    // State, mu, counters and registered outputs.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_r      <= IDLE;
            mu_r         <= MU_MIN;
            rst_cnt_r    <= 1'b0;
            run_cnt_r    <= {RUN_W{1'b0}};
            iter_rst_n_r <= 1'b0;
            mu_valid_r   <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            mu_r         <= mu_nxt_s;
            rst_cnt_r    <= rst_cnt_nxt_s;
            run_cnt_r    <= run_cnt_nxt_s;
            iter_rst_n_r <= iter_rst_n_nxt_s;
            mu_valid_r   <= mu_valid_nxt_s;
            busy_r       <= busy_nxt_s;
        end
    end

    assign mu         = mu_r;
    assign iter_rst_n = iter_rst_n_r;
    assign mu_valid   = mu_valid_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_mu_sweep_ctrl.sv
// Directed bench for mu_sweep_ctrl: a vector table of button/auto frames plus
// hand-written reset, timeout, glitch, wrap and saturation sequences.
module tb_mu_sweep_ctrl;

    localparam int DEB = 16;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        frame_start = 1'b0;
    logic        btn_up = 1'b0;
    logic        btn_down = 1'b0;
    logic        auto_en = 1'b0;
    logic        iter_done = 1'b0;
    logic [17:0] mu;
    logic        iter_rst_n, mu_valid, busy;

    int tests = 0;
    int fails = 0;

    mu_sweep_ctrl #(.DEB_CYCLES(DEB)) dut (
        .CLK(CLK), .RST(RST), .frame_start(frame_start), .btn_up(btn_up),
        .btn_down(btn_down), .auto_en(auto_en), .iter_done(iter_done),
        .mu(mu), .iter_rst_n(iter_rst_n), .mu_valid(mu_valid), .busy(busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        up;
        logic        dn;
        logic        au;
        logic [17:0] exp_mu;
        logic        exp_chg;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wait_hold();
        bit ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (busy == 1'b0 && mu_valid == 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(posedge CLK); #1;
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL wait_hold: HOLD not reached within 3000 cycles");
        end
    endtask

    task automatic press(input logic up, input logic dn);
        @(negedge CLK);
        btn_up = up;
        btn_down = dn;
        repeat (DEB + 8) @(negedge CLK);
        btn_up = 1'b0;
        btn_down = 1'b0;
        repeat (DEB + 8) @(negedge CLK);
        #1;
    endtask

    task automatic do_frame(input string name, input logic [17:0] exp_mu, input logic exp_chg);
        wait_hold();
        @(negedge CLK);
        frame_start = 1'b1;
        @(posedge CLK); #1;
        chk({name, ".mu"}, 32'(mu), 32'(exp_mu));
        chk({name, ".busy"}, 32'(busy), 32'(exp_chg));
        chk({name, ".mu_valid"}, 32'(mu_valid), 32'(!exp_chg));
        @(negedge CLK);
        frame_start = 1'b0;
    endtask

    task automatic sweep(input int n);
        for (int k = 0; k < n; k++) begin
            wait_hold();
            @(negedge CLK);
            frame_start = 1'b1;
            @(negedge CLK);
            frame_start = 1'b0;
            #1;
        end
        @(posedge CLK); #1;
        wait_hold();
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        #1;
        wait_hold();
    endtask

    initial begin
        int low;
        int runs;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 18'h2_0400, 1'b1};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 18'h2_0800, 1'b1};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 18'h2_0400, 1'b1};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 18'h2_0000, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 18'h2_0000, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 18'h2_0040, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 18'h2_0040, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 18'h2_0040, 1'b0};
        vecs[8] = '{1'b0, 1'b0, 1'b1, 18'h2_0080, 1'b1};
        vecs[9] = '{1'b0, 1'b1, 1'b1, 18'h2_0000, 1'b1};

        // Reset state, then release with a slow iterator.
        repeat (3) @(posedge CLK);
        #1;
        chk("rst.mu", 32'(mu), 32'h2_0000);
        chk("rst.iter_rst_n", 32'(iter_rst_n), 32'h0);
        chk("rst.mu_valid", 32'(mu_valid), 32'h0);
        chk("rst.busy", 32'(busy), 32'h0);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK); #1;
        chk("idle.iter_rst_n", 32'(iter_rst_n), 32'h1);
        chk("idle.busy", 32'(busy), 32'h0);
        low = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge CLK); #1;
            if (iter_rst_n == 1'b0) low++;
            else break;
        end
        chk("restart.low_cycles", 32'(low), 32'd2);
        chk("run.busy", 32'(busy), 32'h1);
        repeat (299) @(posedge CLK);
        #1;
        chk("run300.busy", 32'(busy), 32'h1);
        chk("run300.mu_valid", 32'(mu_valid), 32'h0);
        @(negedge CLK);
        iter_done = 1'b1;
        @(posedge CLK); #1;
        chk("done.mu_valid", 32'(mu_valid), 32'h1);
        chk("done.busy", 32'(busy), 32'h0);
        chk("done.mu", 32'(mu), 32'h2_0000);

        // Table of button/auto frames starting from mu = 2.0.
        for (int v = 0; v < 10; v++) begin
            auto_en = vecs[v].au;
            if (vecs[v].up || vecs[v].dn) press(vecs[v].up, vecs[v].dn);
            do_frame($sformatf("vec%0d", v), vecs[v].exp_mu, vecs[v].exp_chg);
        end

        // A 10-cycle glitch must not register as a press.
        auto_en = 1'b0;
        @(negedge CLK);
        btn_up = 1'b1;
        repeat (10) @(negedge CLK);
        btn_up = 1'b0;
        repeat (DEB + 8) @(negedge CLK);
        do_frame("glitch", 18'h2_0000, 1'b0);

        // Timeout: iterator never finishes.
        iter_done = 1'b0;
        auto_en = 1'b1;
        do_frame("to_frame", 18'h2_0040, 1'b1);
        runs = 0;
        for (int k = 0; k < 2000; k++) begin
            @(posedge CLK); #1;
            if (busy && iter_rst_n) runs++;
            if (mu_valid) break;
        end
        chk("timeout.run_cycles", 32'(runs), 32'd1024);
        chk("timeout.mu", 32'(mu), 32'h2_0040);

        // frame_start during RUN is ignored; then reset in the middle of RUN.
        do_frame("run_frame", 18'h2_0080, 1'b1);
        repeat (5) @(negedge CLK);
        frame_start = 1'b1;
        @(posedge CLK); #1;
        chk("run_fs.busy", 32'(busy), 32'h1);
        chk("run_fs.mu", 32'(mu), 32'h2_0080);
        @(negedge CLK);
        frame_start = 1'b0;
        repeat (20) @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK); #1;
        chk("run_rst.mu", 32'(mu), 32'h2_0000);
        chk("run_rst.iter_rst_n", 32'(iter_rst_n), 32'h0);
        chk("run_rst.busy", 32'(busy), 32'h0);
        @(negedge CLK);
        RST = 1'b1;
        iter_done = 1'b1;
        #1;
        wait_hold();

        // Auto sweep to 3_FFC0, then wrap to MU_MIN.
        auto_en = 1'b1;
        sweep(2047);
        chk("sweep1.mu", 32'(mu), 32'h3_FFC0);
        do_frame("wrap", 18'h2_0000, 1'b1);

        // Sweep to 3_FE00, then a button press saturates at MU_MAX.
        do_reset();
        auto_en = 1'b1;
        sweep(2040);
        chk("sweep2.mu", 32'(mu), 32'h3_FE00);
        auto_en = 1'b0;
        press(1'b1, 1'b0);
        do_frame("saturate", 18'h3_FFFF, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
